// File: rtl/playback_pkg.sv
// Shared definitions for the instruction playback path: FSM states,
// instruction field layout and direction codes used by the display blocks.
package playback_pkg;

    localparam int INSTR_W    = 4;
    localparam int DIREC_LSB  = 0;
    localparam int TORQUE_LSB = 2;

    localparam logic [1:0] DIR_FWD   = 2'd0;
    localparam logic [1:0] DIR_REV   = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_RUN,
        S_GAP,
        S_PAUSED,
        S_DONE
    } state_t;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; expired flags the final cycle of a loaded interval
// so the owner can switch state on the same edge the count runs out.
module dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             hold,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (!hold && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/instr_playback_sched.sv
// Replays the saved instruction FIFO: fetch, latch, torque-scaled dwell,
// blank gap, repeat; with pause/resume and abort.
module instr_playback_sched
    import playback_pkg::*;
#(
    parameter int STEP_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic               fifo_empty,
    input  logic [INSTR_W-1:0] fifo_data,
    output logic               fifo_rd_en,
    output logic               motion_en,
    output logic [1:0]         direc,
    output logic [1:0]         torque,
    output logic [4:0]         step_idx,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(4 * STEP_CYCLES + 1);
    localparam logic [CNT_W-1:0] STEP_LD = CNT_W'(STEP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);

    // (torque+1)*STEP as shift-add; CNT_W holds 4*STEP so nothing is lost.
    function automatic logic [CNT_W-1:0] dwell_of(input logic [1:0] tq);
        logic [CNT_W-1:0] acc;
        acc = STEP_LD;
        if (tq[0]) acc = acc + STEP_LD;
        if (tq[1]) acc = acc + (STEP_LD << 1);
        return acc;
    endfunction

    state_t           state, next_state, saved_state;
    logic             tmr_load, tmr_hold, tmr_expired;
    logic [CNT_W-1:0] tmr_value;
    logic [1:0]       instr_direc, instr_torque;
    logic             timed_state;

    assign instr_direc  = fifo_data[DIREC_LSB +: 2];
    assign instr_torque = fifo_data[TORQUE_LSB +: 2];
    assign timed_state  = (state == S_RUN) || (state == S_GAP);
    // Pause and abort both freeze the count in the cycle they arrive.
    assign tmr_hold     = !timed_state || pause || abort;

    dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .hold    (tmr_hold),
        .expired (tmr_expired)
    );

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_value  = GAP_LD;
        unique case (state)
            S_IDLE: begin
                if (start) next_state = fifo_empty ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                next_state = abort ? S_IDLE : S_LATCH;
            end
            S_LATCH: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_RUN;
                    tmr_load   = 1'b1;
                    tmr_value  = dwell_of(instr_torque);
                end
            end
            S_RUN: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (pause) begin
                    next_state = S_PAUSED;
                end else if (tmr_expired) begin
                    next_state = S_GAP;
                    tmr_load   = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) next_state = S_IDLE;
                else if (pause) next_state = S_PAUSED;
                else if (tmr_expired) next_state = fifo_empty ? S_DONE : S_FETCH;
            end
            S_PAUSED: begin
                if (abort) next_state = S_IDLE;
                else if (pause) next_state = saved_state;
            end
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            saved_state <= S_IDLE;
            direc       <= 2'b00;
            torque      <= 2'b00;
            step_idx    <= 5'd0;
        end else begin
            state <= next_state;
            if (timed_state && pause && !abort) saved_state <= state;
            if ((abort && state != S_IDLE) || state == S_DONE) begin
                direc  <= 2'b00;
                torque <= 2'b00;
            end else if (state == S_LATCH) begin
                direc    <= instr_direc;
                torque   <= instr_torque;
                step_idx <= sat_inc5(step_idx);
            end
            if (state == S_IDLE && start && !fifo_empty) step_idx <= 5'd0;
        end
    end

    // Gating with abort keeps a same-cycle abort from popping the FIFO.
    assign fifo_rd_en = (state == S_FETCH) && !abort;
    assign motion_en  = (state == S_RUN);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_instr_playback_sched.sv
// Self-checking bench for instr_playback_sched with a behavioural FIFO and a
// per-cycle timeline model built from the playback rules.
module tb_instr_playback_sched;

    localparam int STEP = 10;
    localparam int GAP  = 3;

    typedef struct packed {
        logic       rd;
        logic       mot;
        logic [1:0] dir;
        logic [1:0] tq;
        logic       busy;
        logic       done;
        logic [4:0] step;
    } obs_t;

    typedef struct {
        logic [3:0] ins;
        int         dir;
        int         tq;
        int         run;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pause = 1'b0;
    logic       fifo_empty;
    logic [3:0] fifo_data = 4'h0;
    logic       fifo_rd_en, motion_en, busy, done;
    logic [1:0] direc, torque;
    logic [4:0] step_idx;

    int checks = 0;
    int errors = 0;

    logic [3:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    obs_t       exp_q[$];
    int         start_cyc[$];
    int         pause_cyc[$];
    int         abort_cyc[$];
    logic [3:0] list_q[$];
    int         last_step = 0;

    always #5 clk = ~clk;

    instr_playback_sched #(.STEP_CYCLES(STEP), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .motion_en  (motion_en),
        .direc      (direc),
        .torque     (torque),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done)
    );

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && rd_ptr != wr_ptr) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    function automatic obs_t sample();
        obs_t o;
        o = {fifo_rd_en, motion_en, direc, torque, busy, done, step_idx};
        return o;
    endfunction

    function automatic string show(obs_t o);
        return $sformatf("rd=%b mot=%b dir=%0d tq=%0d busy=%b done=%b step=%0d",
                         o.rd, o.mot, o.dir, o.tq, o.busy, o.done, o.step);
    endfunction

    task automatic check_obs(input string name, input int cyc, input obs_t want);
        obs_t got;
        got = sample();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %s want %s", name, cyc, show(got), show(want));
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic emit(input int n, input int rd, input int mot, input int d, input int t,
                        input int b, input int dn, input int s);
        obs_t o;
        o = {1'(rd), 1'(mot), 2'(d), 2'(t), 1'(b), 1'(dn), 5'(s)};
        repeat (n) exp_q.push_back(o);
    endtask

    task automatic push(input logic [3:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    function automatic bit hit(input int q[$], input int c);
        foreach (q[i]) if (q[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Entered and left at 1 time unit after a rising edge; cycle 0 is the start cycle.
    task automatic run_seq(input string name);
        for (int k = 0; k <= exp_q.size(); k++) begin
            start = hit(start_cyc, k);
            pause = hit(pause_cyc, k);
            abort = hit(abort_cyc, k);
            @(negedge clk);
            if (k > 0) check_obs(name, k, exp_q[k-1]);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        exp_q.delete();
        start_cyc.delete();
        start_cyc.push_back(0);
        pause_cyc.delete();
        abort_cyc.delete();
    endtask

    // Expected timeline: per instruction 1 fetch + 1 latch + (tq+1)*STEP run + GAP,
    // then one done cycle and an idle tail.
    task automatic build_play(input int tail);
        int d = 0;
        int t = 0;
        int s = 0;
        foreach (list_q[i]) begin
            emit(1, 1, 0, d, t, 1, 0, s);
            emit(1, 0, 0, d, t, 1, 0, s);
            d = int'(list_q[i][1:0]);
            t = int'(list_q[i][3:2]);
            s = (s < 31) ? s + 1 : 31;
            emit((t + 1) * STEP, 0, 1, d, t, 1, 0, s);
            emit(GAP, 0, 0, d, t, 1, 0, s);
        end
        emit(1, 0, 0, d, t, 1, 1, s);
        emit(tail, 0, 0, 0, 0, 0, 0, s);
        last_step = s;
    endtask

    task automatic play_list(input string name);
        foreach (list_q[i]) push(list_q[i]);
        build_play(2);
        run_seq(name);
        list_q.delete();
    endtask

    vec_t tbl[6];

    initial begin
        obs_t zero;
        zero = '0;
        tbl[0] = '{4'h0, 0, 0, 10};
        tbl[1] = '{4'h6, 2, 1, 20};
        tbl[2] = '{4'h9, 1, 2, 30};
        tbl[3] = '{4'hF, 3, 3, 40};
        tbl[4] = '{4'hC, 0, 3, 40};
        tbl[5] = '{4'h3, 3, 0, 10};
        start_cyc.push_back(0);

        #2 rst_n = 1'b0;
        #1 check_obs("reset", 0, zero);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        list_q.push_back(4'h6);
        play_list("single_0110");

        list_q.push_back(4'h0);
        list_q.push_back(4'hF);
        list_q.push_back(4'h5);
        play_list("three_instr");

        for (int i = 0; i < 6; i++) begin
            int  run;
            int  got_dir;
            int  got_tq;
            bit  seen_done;
            run = 0;
            got_dir = -1;
            got_tq = -1;
            seen_done = 1'b0;
            push(tbl[i].ins);
            start = 1'b1;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (motion_en) begin
                    if (run == 0) begin
                        got_dir = int'(direc);
                        got_tq = int'(torque);
                    end
                    run++;
                end
                if (done) seen_done = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                if (seen_done) break;
            end
            check_int($sformatf("tbl%0d_run", i), run, tbl[i].run);
            check_int($sformatf("tbl%0d_dir", i), got_dir, tbl[i].dir);
            check_int($sformatf("tbl%0d_tq", i), got_tq, tbl[i].tq);
            check_int($sformatf("tbl%0d_done", i), int'(seen_done), 1);
        end
        last_step = 1;

        // Pause at count 7 in RUN, resume 50 cycles later: 7 more RUN cycles.
        push(4'h3);
        emit(1, 1, 0, 0, 0, 1, 0, 0);
        emit(1, 0, 0, 0, 0, 1, 0, 0);
        emit(4, 0, 1, 3, 0, 1, 0, 1);
        emit(50, 0, 0, 3, 0, 1, 0, 1);
        emit(7, 0, 1, 3, 0, 1, 0, 1);
        emit(GAP, 0, 0, 3, 0, 1, 0, 1);
        emit(1, 0, 0, 3, 0, 1, 1, 1);
        emit(2, 0, 0, 0, 0, 0, 0, 1);
        pause_cyc.push_back(6);
        pause_cyc.push_back(56);
        run_seq("pause_resume");
        last_step = 1;

        // Starts while busy (RUN, GAP, DONE) and pauses in FETCH/LATCH are ignored.
        start_cyc.push_back(5);
        start_cyc.push_back(24);
        start_cyc.push_back(26);
        pause_cyc.push_back(1);
        pause_cyc.push_back(2);
        list_q.push_back(4'h6);
        play_list("busy_start");

        emit(1, 0, 0, 0, 0, 1, 1, last_step);
        emit(2, 0, 0, 0, 0, 0, 0, last_step);
        run_seq("empty_start");

        push(4'h5);
        push(4'hA);
        push(4'h3);
        emit(1, 1, 0, 0, 0, 1, 0, 0);
        emit(1, 0, 0, 0, 0, 1, 0, 0);
        emit(6, 0, 1, 1, 1, 1, 0, 1);
        emit(6, 0, 0, 0, 0, 0, 0, 1);
        abort_cyc.push_back(8);
        run_seq("abort_run");
        check_int("abort_fifo_left", wr_ptr - rd_ptr, 2);

        emit(1, 1, 0, 0, 0, 1, 0, 0);
        emit(1, 0, 0, 0, 0, 1, 0, 0);
        emit(7, 0, 1, 2, 2, 1, 0, 1);
        run_seq("pre_reset");
        rst_n = 1'b0;
        #1 check_obs("async_reset", 10, zero);
        check_int("reset_fifo_left", wr_ptr - rd_ptr, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        list_q.push_back(4'h3);
        build_play(2);
        run_seq("replay_head");
        list_q.delete();
        check_int("replay_fifo_left", wr_ptr - rd_ptr, 0);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) list_q.push_back(4'($urandom_range(0, 15)));
            play_list($sformatf("rand%0d", r));
        end

        for (int j = 0; j < 33; j++) list_q.push_back(4'($urandom_range(0, 15)));
        play_list("saturate");
        check_int("sat_step_idx", int'(step_idx), 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
